// File: rtl/bcd_display_mux_if.sv
// Digit/control bundle between the BCD stage and the display mux.
// The master drives digits and mode bits; the slave returns pins.
interface bcd_display_mux_if;
  logic [3:0] tens_i;
  logic [3:0] ones_i;
  logic       blank_lz_i;
  logic       blink_i;
  logic [6:0] seg_o;
  logic [1:0] dig_o;
  logic       frame_o;

  modport master (
    output tens_i, ones_i, blank_lz_i, blink_i,
    input  seg_o, dig_o, frame_o
  );

  modport slave (
    input  tens_i, ones_i, blank_lz_i, blink_i,
    output seg_o, dig_o, frame_o
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Two-digit time-multiplexed 7-segment driver with dead-time,
// leading-zero blanking, frame-synchronous blink and tear-free capture.
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 1000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  bcd_display_mux_if.slave bus
);

  localparam int CMAX = (REFRESH_DIV > DEAD_CYCLES) ?
                        REFRESH_DIV : DEAD_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  typedef enum logic [1:0] {
    TENS, GAP1, ONES, GAP2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          blank_q, blank_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;
  logic          vis_q, vis_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          frame_q;
  logic          last, cap;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    if (state_q == TENS || state_q == ONES)
      lim = CW'(REFRESH_DIV);
    else
      lim = (DEAD_CYCLES == 0) ? CW'(1) : CW'(DEAD_CYCLES);
    last  = (cnt_q == lim - 1'b1);
    cnt_d = last ? '0 : cnt_q + 1'b1;
    if (last) begin
      unique case (state_q)
        TENS: state_d = (DEAD_CYCLES == 0) ? ONES : GAP1;
        GAP1: state_d = ONES;
        ONES: state_d = (DEAD_CYCLES == 0) ? TENS : GAP2;
        GAP2: state_d = TENS;
        default: state_d = GAP2;
      endcase
    end
    cap = (state_d == TENS) && (state_q != TENS);

    tens_d  = cap ? bus.tens_i     : tens_q;
    ones_d  = cap ? bus.ones_i     : ones_q;
    blank_d = cap ? bus.blank_lz_i : blank_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    vis_d   = vis_q;
    // New frame shows the phase held before this capture's wrap
    if (cap) begin
      if (bus.blink_i) begin
        vis_d = phase_q;
        if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        vis_d   = 1'b1;
        fcnt_d  = '0;
        phase_d = 1'b1;
      end
    end

    seg_d = '0;
    dig_d = '0;
    if (vis_d) begin
      if (state_d == TENS && !(blank_d && tens_d == 4'd0)) begin
        dig_d = 2'b10;
        seg_d = seg_of(tens_d);
      end else if (state_d == ONES) begin
        dig_d = 2'b01;
        seg_d = seg_of(ones_d);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= GAP2;
      cnt_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      blank_q <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      vis_q   <= 1'b1;
      seg_q   <= '0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      blank_q <= blank_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      vis_q   <= vis_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= cap;
    end
  end

  assign bus.seg_o   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign bus.dig_o   = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: frame-position reference model,
// directed scenarios then random digits, modes and resets.
module tb_bcd_display_mux;
  localparam int R  = 4;
  localparam int D  = 1;
  localparam int BF = 2;
  localparam int FR = 2 * (R + D);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_display_mux_if bus_h ();
  bcd_display_mux_if bus_l ();

  assign bus_l.tens_i     = bus_h.tens_i;
  assign bus_l.ones_i     = bus_h.ones_i;
  assign bus_l.blank_lz_i = bus_h.blank_lz_i;
  assign bus_l.blink_i    = bus_h.blink_i;

  bcd_display_mux #(
    .REFRESH_DIV(R), .DEAD_CYCLES(D),
    .BLINK_FRAMES(BF), .ACTIVE_LOW(0)
  ) u_hi (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_h)
  );

  bcd_display_mux #(
    .REFRESH_DIV(R), .DEAD_CYCLES(D),
    .BLINK_FRAMES(BF), .ACTIVE_LOW(1)
  ) u_lo (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus_l)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [16];
  int         pos;
  int         bcount;
  logic [3:0] m_t, m_o;
  logic       m_blank, m_vis;
  logic [6:0] e_seg;
  logic [1:0] e_dig;
  logic       e_frame;

  task automatic model_edge();
    if (!rst_n) begin
      pos = FR - 1;
      m_t = 0; m_o = 0;
      m_blank = 0; m_vis = 1;
      bcount = 0;
    end else begin
      pos = (pos + 1) % FR;
      if (pos == 0) begin
        m_t = bus_h.tens_i;
        m_o = bus_h.ones_i;
        m_blank = bus_h.blank_lz_i;
        if (bus_h.blink_i) begin
          m_vis = ((bcount / BF) % 2) == 0;
          bcount++;
        end else begin
          m_vis = 1;
          bcount = 0;
        end
      end
    end
    e_seg = '0;
    e_dig = '0;
    e_frame = (pos == 0);
    if (m_vis) begin
      if (pos < R) begin
        if (!(m_blank && m_t == 0)) begin
          e_dig = 2'b10;
          e_seg = segtab[m_t];
        end
      end else if (pos >= R + D && pos < 2 * R + D) begin
        e_dig = 2'b01;
        e_seg = segtab[m_o];
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    tests++;
    assert (bus_h.seg_o === e_seg) else begin
      fails++;
      $error("FAIL %s seg pos=%0d got %h exp %h",
             tag, pos, bus_h.seg_o, e_seg);
    end
    tests++;
    assert (bus_h.dig_o === e_dig) else begin
      fails++;
      $error("FAIL %s dig pos=%0d got %b exp %b",
             tag, pos, bus_h.dig_o, e_dig);
    end
    tests++;
    assert (bus_h.frame_o === e_frame) else begin
      fails++;
      $error("FAIL %s frame pos=%0d got %b exp %b",
             tag, pos, bus_h.frame_o, e_frame);
    end
    tests++;
    assert (bus_l.seg_o === ~e_seg) else begin
      fails++;
      $error("FAIL %s seg_al pos=%0d got %h exp %h",
             tag, pos, bus_l.seg_o, ~e_seg);
    end
    tests++;
    assert (bus_l.dig_o === ~e_dig) else begin
      fails++;
      $error("FAIL %s dig_al pos=%0d got %b exp %b",
             tag, pos, bus_l.dig_o, ~e_dig);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic set_in(input int t, input int o,
                        input bit bl, input bit bk);
    bus_h.tens_i     = 4'(t);
    bus_h.ones_i     = 4'(o);
    bus_h.blank_lz_i = bl;
    bus_h.blink_i    = bk;
  endtask

  initial begin
    segtab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40,
               7'h40, 7'h40, 7'h40, 7'h40};
    pos = FR - 1;
    set_in(4, 2, 0, 0);
    rst_n = 1'b0;
    run("reset", 2);
    rst_n = 1'b1;
    run("basic42", 2 * FR);

    for (int g = 0; g < FR && pos != 2; g++) tick("align");
    bus_h.ones_i = 4'd7;
    run("notear", 2 * FR);

    set_in(0, 5, 1, 0);
    run("blank05", 2 * FR);
    set_in(0, 5, 0, 0);
    run("noblank05", 2 * FR);
    set_in(0, 0, 1, 0);
    run("blank00", 2 * FR);

    set_in(12, 9, 0, 0);
    run("invalid", 2 * FR);

    set_in(3, 8, 0, 1);
    run("blink", 9 * FR);
    bus_h.blink_i = 1'b0;
    run("unblink", 2 * FR);

    for (int g = 0; g < FR && pos != R + D + 1; g++) tick("align");
    rst_n = 1'b0;
    tick("midreset");
    rst_n = 1'b1;
    run("postreset", 2 * FR);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        bus_h.tens_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        bus_h.ones_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0)
        bus_h.blank_lz_i = ~bus_h.blank_lz_i;
      if ($urandom_range(0, 60) == 0)
        bus_h.blink_i = ~bus_h.blink_i;
      rst_n = ($urandom_range(0, 400) != 0);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
